load_store_accel: RTL and testbench

Memory-streaming byte-sum engine. Loads `count` consecutive 32-bit words from a load region. Each word is passed through an internal accelerator that sums its four bytes. Each result is written to the matching word of a store region. It sits between a host/controller (start/done) and a single-word memory port with request/complete handshakes.

---
 rtl/load_store_accel_pkg.sv | 20 ++
 rtl/load_store_accel_byte_sum_accel.sv | 36 +++
 rtl/load_store_accel.sv | 161 ++++++++++++++++
 tb/tb_load_store_accel.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_accel_pkg.sv
// Shared types and constants for the load/store byte-sum streaming engine.
package load_store_accel_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 32;
    localparam int unsigned DEFAULT_ADDR_WIDTH = 22;
    localparam int unsigned COUNT_WIDTH        = 22;
    localparam int unsigned WORD_STRIDE        = 4;

    typedef enum logic [2:0] {
        StIdle,
        StLoadReq,
        StLoadWait,
        StAccStart,
        StAccWait,
        StStoreReq,
        StStoreWait,
        StFinish
    } state_t;

endpackage

// File: rtl/load_store_accel_byte_sum_accel.sv
// Single-word accelerator: registers the zero-extended sum of the four bytes
// one cycle after start, with a matching one-cycle done pulse.
module byte_sum_accel (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        done
);

    logic [9:0]  w_sum;
    logic [31:0] r_data_out;
    logic        r_done;

    always_comb begin
        w_sum = 10'(data_in[7:0]) + 10'(data_in[15:8]) + 10'(data_in[23:16])
              + 10'(data_in[31:24]);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_data_out <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= start;
            if (start) begin
                r_data_out <= {22'd0, w_sum};
            end
        end
    end

    assign data_out = r_data_out;
    assign done     = r_done;

endmodule

// File: rtl/load_store_accel.sv
// Streams count words from a load region through byte_sum_accel and writes each
// result to the matching word of a store region, one request at a time.
module load_store_accel
    import load_store_accel_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [ADDR_WIDTH-1:0]  load_base_addr,
    input  logic [ADDR_WIDTH-1:0]  store_base_addr,
    input  logic [COUNT_WIDTH-1:0] count,
    output logic                   done,
    output logic                   load_req,
    output logic [ADDR_WIDTH-1:0]  load_addr,
    input  logic [DATA_WIDTH-1:0]  load_data,
    input  logic                   load_complete,
    output logic                   store_req,
    output logic [ADDR_WIDTH-1:0]  store_addr,
    output logic [DATA_WIDTH-1:0]  store_data,
    input  logic                   store_complete
);

    localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(WORD_STRIDE);

    state_t r_state;
    state_t w_state_d;

    logic [COUNT_WIDTH-1:0] r_index;
    logic [COUNT_WIDTH-1:0] r_count;
    logic [ADDR_WIDTH-1:0]  r_load_addr;
    logic [ADDR_WIDTH-1:0]  r_store_addr;
    logic [ADDR_WIDTH-1:0]  r_store_ptr;
    logic [DATA_WIDTH-1:0]  r_load_data;
    logic [DATA_WIDTH-1:0]  r_store_data;
    logic                   r_load_req;
    logic                   r_store_req;
    logic                   r_done;

    logic                   w_accept;
    logic                   w_load_fire;
    logic                   w_acc_fire;
    logic                   w_store_fire;
    logic                   w_last;
    logic                   w_accel_start;
    logic                   w_accel_done;
    logic [DATA_WIDTH-1:0]  w_accel_data;

    assign w_last = ((r_index + COUNT_WIDTH'(1)) == r_count);

    byte_sum_accel u_accel (
        .clk      (clk),
        .reset    (reset),
        .start    (w_accel_start),
        .data_in  (r_load_data),
        .data_out (w_accel_data),
        .done     (w_accel_done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d     = r_state;
        w_accept      = 1'b0;
        w_load_fire   = 1'b0;
        w_acc_fire    = 1'b0;
        w_store_fire  = 1'b0;
        w_accel_start = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (start) begin
                    w_accept  = 1'b1;
                    w_state_d = (count == '0) ? StFinish : StLoadReq;
                end
            end
            StLoadReq:  w_state_d = StLoadWait;
            StLoadWait: begin
                if (load_complete) begin
                    w_load_fire = 1'b1;
                    w_state_d   = StAccStart;
                end
            end
            StAccStart: begin
                w_accel_start = 1'b1;
                w_state_d     = StAccWait;
            end
            StAccWait: begin
                if (w_accel_done) begin
                    w_acc_fire = 1'b1;
                    w_state_d  = StStoreReq;
                end
            end
            StStoreReq:  w_state_d = StStoreWait;
            StStoreWait: begin
                if (store_complete) begin
                    w_store_fire = 1'b1;
                    w_state_d    = w_last ? StFinish : StLoadReq;
                end
            end
            StFinish: w_state_d = StIdle;
            default:  w_state_d = StIdle;
        endcase
    end

    // Request/done strobes are registered from the next state so they line up
    // exactly with the cycle spent in the corresponding state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_load_req   <= 1'b0;
            r_store_req  <= 1'b0;
            r_done       <= 1'b0;
            r_index      <= '0;
            r_count      <= '0;
            r_load_addr  <= '0;
            r_store_addr <= '0;
            r_store_ptr  <= '0;
            r_load_data  <= '0;
            r_store_data <= '0;
        end else begin
            r_load_req  <= (w_state_d == StLoadReq);
            r_store_req <= (w_state_d == StStoreReq);
            r_done      <= (w_state_d == StFinish);
            if (w_accept) begin
                r_count     <= count;
                r_index     <= '0;
                r_load_addr <= load_base_addr;
                r_store_ptr <= store_base_addr;
            end
            if (w_load_fire) begin
                r_load_data <= load_data;
            end
            if (w_acc_fire) begin
                r_store_addr <= r_store_ptr;
                r_store_data <= w_accel_data;
            end
            if (w_store_fire) begin
                r_index     <= r_index + COUNT_WIDTH'(1);
                r_store_ptr <= r_store_ptr + STRIDE;
                if (!w_last) begin
                    r_load_addr <= r_load_addr + STRIDE;
                end
            end
        end
    end

    assign done       = r_done;
    assign load_req   = r_load_req;
    assign load_addr  = r_load_addr;
    assign store_req  = r_store_req;
    assign store_addr = r_store_addr;
    assign store_data = r_store_data;

endmodule

// File: tb/tb_load_store_accel.sv
// Directed and randomized jobs against a memory responder and a byte-sum reference model.
module tb_load_store_accel;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [21:0] load_base_addr;
    logic [21:0] store_base_addr;
    logic [21:0] count;
    logic        done;
    logic        load_req;
    logic [21:0] load_addr;
    logic [31:0] load_data;
    logic        load_complete;
    logic        store_req;
    logic [21:0] store_addr;
    logic [31:0] store_data;
    logic        store_complete;

    int n_checks = 0;
    int n_errors = 0;

    load_store_accel dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .load_base_addr  (load_base_addr),
        .store_base_addr (store_base_addr),
        .count           (count),
        .done            (done),
        .load_req        (load_req),
        .load_addr       (load_addr),
        .load_data       (load_data),
        .load_complete   (load_complete),
        .store_req       (store_req),
        .store_addr      (store_addr),
        .store_data      (store_data),
        .store_complete  (store_complete)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Backing memory for loads; stores are logged separately in order.
    logic [31:0] mem [int];
    logic [21:0] wr_addr_q [$];
    logic [31:0] wr_data_q [$];

    function automatic logic [31:0] mem_rd(input logic [21:0] a);
        return mem.exists(int'(a)) ? mem[int'(a)] : 32'h5A5A_0000 ^ {10'd0, a};
    endfunction

    function automatic logic [31:0] ref_sum(input logic [31:0] w);
        int s = 0;
        for (int b = 0; b < 4; b++) s += int'((w >> (8 * b)) & 32'hFF);
        return 32'(s);
    endfunction

    // Memory responder state
    int          cyc = 0;
    int          load_lat = 1;
    int          store_lat = 1;
    int          n_load, n_store, n_done;
    bit          ld_pend = 0, st_pend = 0;
    int          ld_cnt, st_cnt, lc_cyc, sc_cyc;
    logic [21:0] ld_a, st_a;
    logic [31:0] st_d;

    initial begin
        load_complete  = 1'b0;
        store_complete = 1'b0;
        load_data      = '0;
        forever begin
            @(posedge clk); #1;
            cyc++;
            load_complete  = 1'b0;
            store_complete = 1'b0;
            load_data      = $urandom;
            if (!reset) begin
                ld_pend = 0;
                st_pend = 0;
                continue;
            end
            if (ld_pend) begin
                check("load_addr_held", load_addr, ld_a);
                ld_cnt--;
                if (ld_cnt == 0) begin
                    load_complete = 1'b1;
                    load_data     = mem_rd(ld_a);
                    ld_pend       = 0;
                    lc_cyc        = cyc;
                end
            end
            if (st_pend) begin
                check("store_addr_held", store_addr, st_a);
                check("store_data_held", store_data, st_d);
                st_cnt--;
                if (st_cnt == 0) begin
                    store_complete = 1'b1;
                    wr_addr_q.push_back(st_a);
                    wr_data_q.push_back(st_d);
                    st_pend = 0;
                    sc_cyc  = cyc;
                end
            end
            if (load_req) begin
                n_load++;
                check("load_req_while_pending", 64'(ld_pend), 0);
                ld_pend = 1;
                ld_a    = load_addr;
                ld_cnt  = load_lat;
            end
            if (store_req) begin
                n_store++;
                check("store_req_latency", 64'(cyc - lc_cyc), 3);
                st_pend = 1;
                st_a    = store_addr;
                st_d    = store_data;
                st_cnt  = store_lat;
            end
            if (done) begin
                n_done++;
                if (n_store > 0) check("done_latency", 64'(cyc - sc_cyc), 1);
            end
        end
    end

    task automatic fill(input logic [21:0] lb, input int cnt);
        for (int i = 0; i < cnt; i++) mem[int'(22'(int'(lb) + 4 * i))] = $urandom;
    endtask

    task automatic run_job(input logic [21:0] lb, input logic [21:0] sb, input int cnt,
                           input int restart_at);
        int budget;
        int k;
        logic [21:0] ea;
        n_load = 0;
        n_store = 0;
        n_done = 0;
        wr_addr_q.delete();
        wr_data_q.delete();
        load_base_addr  = lb;
        store_base_addr = sb;
        count           = 22'(cnt);
        start           = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        check("load_req_latency", load_req, 64'(cnt != 0));
        check("zero_count_done", done, 64'(cnt == 0));
        budget = 40 + cnt * (load_lat + store_lat + 10);
        k = 0;
        while (n_done == 0 && k < budget) begin
            start = (k == restart_at);
            @(posedge clk); #2;
            k++;
        end
        start = 1'b0;
        check("done_within_budget", 64'(k < budget), 1);
        repeat (3) @(posedge clk);
        #2;
        check("done_pulses", 64'(n_done), 1);
        check("load_req_pulses", 64'(n_load), 64'(cnt));
        check("store_req_pulses", 64'(n_store), 64'(cnt));
        check("stores_logged", 64'(wr_addr_q.size()), 64'(cnt));
        for (int i = 0; i < cnt && i < wr_addr_q.size(); i++) begin
            ea = 22'(int'(sb) + 4 * i);
            check("store_addr", wr_addr_q[i], ea);
            check("store_data", wr_data_q[i], ref_sum(mem_rd(22'(int'(lb) + 4 * i))));
        end
    endtask

    initial begin
        int k;
        logic [21:0] lb, sb;
        int cnt;
        reset           = 1'b0;
        start           = 1'b0;
        load_base_addr  = '0;
        store_base_addr = '0;
        count           = '0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_done", done, 0);
        check("rst_load_req", load_req, 0);
        check("rst_store_req", store_req, 0);
        check("rst_load_addr", load_addr, 0);
        check("rst_store_addr", store_addr, 0);
        check("rst_store_data", store_data, 0);
        reset = 1'b1;
        @(posedge clk); #2;

        mem[0] = 32'h0102_0304;
        run_job(22'h0, 22'h4, 1, -1);
        check("plan_sum_0a", wr_data_q.size() > 0 ? wr_data_q[0] : 32'hX, 32'h0000_000A);

        mem[32'h20] = 32'hFFFF_FFFF;
        run_job(22'h20, 22'h80, 1, -1);
        check("plan_sum_3fc", wr_data_q.size() > 0 ? wr_data_q[0] : 32'hX, 32'h0000_03FC);

        mem[32'h40] = 32'h0000_0001;
        mem[32'h44] = 32'h1020_3040;
        mem[32'h48] = 32'h8080_8080;
        run_job(22'h40, 22'h100, 3, -1);
        check("plan_three_last", wr_data_q.size() > 2 ? wr_data_q[2] : 32'hX, 32'h0000_0200);

        run_job(22'h123, 22'h456, 0, -1);

        load_lat = 5;
        fill(22'h200, 1);
        run_job(22'h200, 22'h300, 1, 2);
        load_lat = 1;

        // Unaligned base that wraps past the top of the address space
        fill(22'h3F_FFFA, 4);
        run_job(22'h3F_FFFA, 22'h3F_FFF8, 4, -1);

        for (int j = 0; j < 6; j++) begin
            lb        = 22'($urandom);
            sb        = 22'($urandom);
            cnt       = int'($urandom_range(1, 6));
            load_lat  = int'($urandom_range(1, 4));
            store_lat = int'($urandom_range(1, 4));
            fill(lb, cnt);
            run_job(lb, sb, cnt, (j % 2 == 0) ? 1 : -1);
        end

        // Abort in STORE_WAIT via asynchronous reset
        load_lat  = 1;
        store_lat = 6;
        n_done    = 0;
        fill(22'h500, 2);
        load_base_addr  = 22'h500;
        store_base_addr = 22'h600;
        count           = 22'd2;
        start           = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        k = 0;
        while (!st_pend && k < 50) begin
            @(posedge clk); #2;
            k++;
        end
        check("reach_store_wait", 64'(st_pend), 1);
        @(posedge clk); #3;
        reset = 1'b0;
        #1;
        check("abort_done", done, 0);
        check("abort_load_req", load_req, 0);
        check("abort_store_req", store_req, 0);
        check("abort_load_addr", load_addr, 0);
        check("abort_store_addr", store_addr, 0);
        check("abort_store_data", store_data, 0);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("abort_no_done", 64'(n_done), 0);
        store_lat = 1;
        fill(22'h700, 1);
        run_job(22'h700, 22'h800, 1, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
